line_fill_buffer: RTL and testbench
===================================

Name: line_fill_buffer

Overview:
- Memory-side responder for the cache controller's line-fill request (LB_Enable / LB_FirstWord / LB_Completed / LineAddress).
- On a request it issues one AXI4 WRAP read burst starting at the missed word, so the critical word arrives first.
- It assembles the full line and reports critical-word and line-complete events back to the controller.
- It sits between the data-cache controller and the AXI read channels.

Parameters:
WORDS_PER_LINE, 8, words per cache line; power of two, 2..16
OFF_W, 3, log2(WORDS_PER_LINE), word-offset width
BYTE_OFF, 2, byte-offset bits inside a 32-bit word

Ports:
Clk  in  1  clock
Rst  in  1  synchronous active-high reset
En  in  1  fill request level from controller (LB_Enable)
WordAddress  in  32  byte address of the missed word, sampled at request acceptance
FirstWord  out  1  one-cycle pulse: critical word valid on CritWord
Completed  out  1  whole line captured; level, held until En low
LineAddress  out  32  line base address of current/last fill
CritWord  out  32  critical word data
LineData  out  32*WORDS_PER_LINE  assembled line; word i at bits [32i+31:32i]
Busy  out  1  fill in progress (ADDR or DATA state)
Error  out  1  any beat returned RRESP != OKAY in current fill
M_ARADDR  out  32  burst start address
M_ARLEN  out  8  WORDS_PER_LINE-1
M_ARSIZE  out  3  3'b010
M_ARBURST  out  2  2'b10 (WRAP)
M_ARVALID  out  1  address valid
M_ARREADY  in  1  address accepted
M_RDATA  in  32  read data
M_RRESP  in  2  read response
M_RLAST  in  1  last beat
M_RVALID  in  1  data valid
M_RREADY  out  1  data ready

Behaviour:
- Reset values: all outputs 0, LineData 0, state IDLE, beat counter 0. Reset mid-burst returns to IDLE immediately; the memory side is reset by the same Rst.
- M_ARLEN, M_ARSIZE, M_ARBURST are constants.
- States: IDLE, ADDR, DATA, DONE.
- IDLE:
  - En=1 → latch crit_off = WordAddress[BYTE_OFF+OFF_W-1:BYTE_OFF].
  - LineAddress <= WordAddress with low BYTE_OFF+OFF_W bits zeroed.
  - M_ARADDR <= WordAddress with low BYTE_OFF bits zeroed.
  - Clear Error and counter; go ADDR.
- ADDR:
  - M_ARVALID=1, Busy=1. ARVALID is held until M_ARREADY; address stays stable.
  - On handshake, the next cycle has ARVALID=0, M_RREADY=1, state DATA.
- DATA:
  - M_RREADY=1. Each cycle with RVALID&RREADY writes word slot (crit_off+count) mod WORDS_PER_LINE, then count++.
  - First beat (count==0): CritWord <= RDATA; FirstWord=1 in the following cycle only.
  - RRESP != 2'b00 on any beat sets Error (sticky until the next request).
  - Beat with count==WORDS_PER_LINE-1, or RLAST: the next cycle has state DONE, Completed=1, Busy=0, RREADY=0.
  - RLAST arriving early ends the burst and sets Error. A missing RLAST on the final beat is ignored.
- DONE:
  - Completed=1; LineData, CritWord and LineAddress are stable.
  - En=0 → IDLE next cycle, Completed=0.
  - En=1 → remain; a new fill needs En low for at least one cycle.
- En is sampled only in IDLE and DONE. Dropping En during ADDR/DATA does not abort the burst; DONE is reached and left the next cycle if En is still 0.
- WRAP order: beats for crit_off=k cover words k, k+1, …, W-1, 0, …, k-1. The address never crosses the line boundary.
- FirstWord and Completed are never high in the same cycle, since WORDS_PER_LINE ≥ 2.
- LineAddress keeps its value in IDLE, so the controller can compare lines after completion.
- Latency with zero-wait memory: En@t0 → ARVALID@t1, handshake@t1 → first beat@t2 → FirstWord@t3 → last beat@t9 → Completed@t10 (W=8).

Test Plan:
- Aligned fill: WordAddress=0x0000_1200, zero-wait memory returns 0xA0..0xA7 → ARADDR=0x1200, ARLEN=7, ARBURST=2; FirstWord pulse with CritWord=0xA0; Completed@t10; LineData word i = 0xA0+i; LineAddress=0x1200.
- Critical-word-first: WordAddress=0x0000_0F34 (offset 5), beats 0xB5,0xB6,0xB7,0xB0..0xB4 → CritWord=0xB5, word5=0xB5, word0=0xB0, LineAddress=0x0F20.
- Backpressure: ARREADY low 3 cycles, RVALID toggling 1/0 → ARADDR stable while ARVALID high; 8 beats captured correctly; Completed only after the 8th accepted beat.
- Error/handshake: beat 3 returns RRESP=2'b10 → Error=1 through DONE; Completed held while En=1; En low → IDLE, Completed=0; next request clears Error.
- Abort/reset: drop En after 2 beats → burst completes, DONE for one cycle, then IDLE. Rst asserted mid-DATA → next cycle all outputs 0, state IDLE; a following request works normally.

Source files
------------

// File: rtl/line_fill_buffer.sv
// line_fill_buffer
// Memory-side responder for a data-cache line fill. A fill request (En) issues
// one AXI4 WRAP read burst starting at the missed word, so the critical word
// comes back first. The line is assembled in LineData, and the controller is
// told when the critical word is valid (FirstWord) and when the line is
// complete (Completed).
//
// Ports:
//   Clk, Rst       clock, synchronous active-high reset
//   En             fill request level (sampled in IDLE and DONE only)
//   WordAddress    byte address of the missed word
//   FirstWord      one-cycle pulse, CritWord valid
//   Completed      line captured, held until En drops
//   LineAddress    line base address of current/last fill
//   CritWord       critical word data
//   LineData       assembled line, word i at [32i+31:32i]
//   Busy           fill in progress (ADDR or DATA)
//   Error          a beat returned non-OKAY or the burst ended early
//   M_AR*/M_R*     AXI4 read address / read data channels
module line_fill_buffer #(
  parameter int WORDS_PER_LINE = 8,
  parameter int OFF_W          = 3,
  parameter int BYTE_OFF       = 2
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         En,
  input  logic [31:0]                  WordAddress,
  output logic                         FirstWord,
  output logic                         Completed,
  output logic [31:0]                  LineAddress,
  output logic [31:0]                  CritWord,
  output logic [32*WORDS_PER_LINE-1:0] LineData,
  output logic                         Busy,
  output logic                         Error,
  output logic [31:0]                  M_ARADDR,
  output logic [7:0]                   M_ARLEN,
  output logic [2:0]                   M_ARSIZE,
  output logic [1:0]                   M_ARBURST,
  output logic                         M_ARVALID,
  input  logic                         M_ARREADY,
  input  logic [31:0]                  M_RDATA,
  input  logic [1:0]                   M_RRESP,
  input  logic                         M_RLAST,
  input  logic                         M_RVALID,
  output logic                         M_RREADY
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int                 LINE_LSB = BYTE_OFF + OFF_W;
  localparam logic [OFF_W-1:0]   LAST_CNT = OFF_W'(WORDS_PER_LINE - 1);

  logic [1:0]       state;
  logic [OFF_W-1:0] critOff;
  logic [OFF_W-1:0] beatCnt;
  logic [OFF_W-1:0] slot;

  // Burst shape is fixed: a full line of 32-bit words in WRAP mode.
  assign M_ARLEN   = 8'(WORDS_PER_LINE - 1);
  assign M_ARSIZE  = 3'b010;
  assign M_ARBURST = 2'b10;

  // Destination word of the current beat; the OFF_W-bit add wraps modulo the line.
  assign slot = critOff + beatCnt;

  // Fill sequencer: request capture, address phase, beat capture, completion hold.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= ST_IDLE;
      critOff     <= {OFF_W{1'b0}};
      beatCnt     <= {OFF_W{1'b0}};
      FirstWord   <= 1'b0;
      Completed   <= 1'b0;
      LineAddress <= 32'd0;
      CritWord    <= 32'd0;
      LineData    <= {(32*WORDS_PER_LINE){1'b0}};
      Busy        <= 1'b0;
      Error       <= 1'b0;
      M_ARADDR    <= 32'd0;
      M_ARVALID   <= 1'b0;
      M_RREADY    <= 1'b0;
    end else begin
      FirstWord <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (En) begin
            critOff     <= WordAddress[LINE_LSB-1:BYTE_OFF];
            LineAddress <= {WordAddress[31:LINE_LSB], {LINE_LSB{1'b0}}};
            M_ARADDR    <= {WordAddress[31:BYTE_OFF], {BYTE_OFF{1'b0}}};
            beatCnt     <= {OFF_W{1'b0}};
            Error       <= 1'b0;
            M_ARVALID   <= 1'b1;
            Busy        <= 1'b1;
            state       <= ST_ADDR;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ADDR: begin
          if (M_ARREADY) begin
            M_ARVALID <= 1'b0;
            M_RREADY  <= 1'b1;
            state     <= ST_DATA;
          end else begin
            state <= ST_ADDR;
          end
        end
        ST_DATA: begin
          if (M_RVALID) begin
            LineData[32*slot +: 32] <= M_RDATA;
            beatCnt                 <= beatCnt + {{(OFF_W-1){1'b0}}, 1'b1};
            if (beatCnt == {OFF_W{1'b0}}) begin
              CritWord  <= M_RDATA;
              FirstWord <= 1'b1;
            end else begin
              CritWord <= CritWord;
            end
            // Early RLAST truncates the line and is flagged; a missing RLAST
            // on the final beat is tolerated because the count ends the burst.
            if ((M_RRESP != 2'b00) || (M_RLAST && (beatCnt != LAST_CNT))) begin
              Error <= 1'b1;
            end else begin
              Error <= Error;
            end
            if ((beatCnt == LAST_CNT) || M_RLAST) begin
              Completed <= 1'b1;
              Busy      <= 1'b0;
              M_RREADY  <= 1'b0;
              state     <= ST_DONE;
            end else begin
              state <= ST_DATA;
            end
          end else begin
            state <= ST_DATA;
          end
        end
        ST_DONE: begin
          // A new fill needs En to drop for at least one cycle first.
          if (!En) begin
            Completed <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            state <= ST_DONE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          Busy      <= 1'b0;
          M_ARVALID <= 1'b0;
          M_RREADY  <= 1'b0;
          Completed <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_fill_buffer.sv
module tb_line_fill_buffer;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic         En = 1'b0;
  logic [31:0]  WordAddress = 32'd0;
  logic         FirstWord, Completed, Busy, Error;
  logic [31:0]  LineAddress, CritWord, M_ARADDR;
  logic [255:0] LineData;
  logic [7:0]   M_ARLEN;
  logic [2:0]   M_ARSIZE;
  logic [1:0]   M_ARBURST;
  logic         M_ARVALID, M_RREADY;
  logic         M_ARREADY = 1'b0;
  logic [31:0]  M_RDATA = 32'd0;
  logic [1:0]   M_RRESP = 2'b00;
  logic         M_RLAST = 1'b0;
  logic         M_RVALID = 1'b0;

  int checks = 0;
  int errors = 0;

  // Observations from the last run_fill
  int          obsArCyc, obsFirstCyc, obsCompCyc, obsFirstCount, obsCompBeats, arUnstable;
  logic [31:0] obsArAddr, obsCrit;
  logic        obsError, obsErrAtAr, aborted;

  line_fill_buffer #(.WORDS_PER_LINE(8), .OFF_W(3), .BYTE_OFF(2)) dut (
    .Clk(Clk), .Rst(Rst), .En(En), .WordAddress(WordAddress),
    .FirstWord(FirstWord), .Completed(Completed), .LineAddress(LineAddress),
    .CritWord(CritWord), .LineData(LineData), .Busy(Busy), .Error(Error),
    .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE),
    .M_ARBURST(M_ARBURST), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RLAST(M_RLAST),
    .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
  );

  always #5 Clk = ~Clk;

  // Memory-side stimulus for one fill. Inputs are driven and outputs observed
  // on the falling edge; cycle 1 is the first falling edge after En rises.
  task automatic run_fill(input logic [31:0] addr, input logic [31:0] dbase,
                          input int arDelay, input bit toggle, input int errBeat,
                          input int dropAt, input int rstAt);
    int arWait;
    int beats;
    bit arSeen;
    logic [2:0] crit;
    logic [31:0] arFirst;
    crit = addr[4:2];
    obsArCyc = -1; obsFirstCyc = -1; obsCompCyc = -1; obsFirstCount = 0;
    obsCompBeats = -1; arUnstable = 0; obsError = 1'b0; obsErrAtAr = 1'b1;
    aborted = 1'b0; arWait = 0; beats = 0; arSeen = 1'b0; arFirst = 32'd0;
    @(negedge Clk);
    En = 1'b1; WordAddress = addr;
    for (int cyc = 1; cyc < 60; cyc++) begin
      @(negedge Clk);
      if (M_ARVALID) begin
        if (!arSeen) begin
          arSeen = 1'b1; arFirst = M_ARADDR; obsArAddr = M_ARADDR;
          obsArCyc = cyc; obsErrAtAr = Error;
        end else if (M_ARADDR !== arFirst) begin
          arUnstable++;
        end
      end
      if (FirstWord) begin
        obsFirstCount++;
        if (obsFirstCyc < 0) begin obsFirstCyc = cyc; obsCrit = CritWord; end
      end
      if (Completed) begin
        obsCompCyc = cyc; obsCompBeats = beats; obsError = Error;
        break;
      end
      M_ARREADY = M_ARVALID && (arWait >= arDelay);
      if (M_ARVALID) arWait++;
      if (M_RREADY && beats < 8 && (!toggle || (cyc % 2 == 0))) begin
        M_RVALID = 1'b1;
        M_RDATA  = dbase + 32'(3'(crit + beats[2:0]));
        M_RRESP  = (beats == errBeat) ? 2'b10 : 2'b00;
        M_RLAST  = (beats == 7);
        beats++;
      end else begin
        M_RVALID = 1'b0; M_RDATA = 32'd0; M_RRESP = 2'b00; M_RLAST = 1'b0;
      end
      if (dropAt >= 0 && beats == dropAt) En = 1'b0;
      if (rstAt >= 0 && beats == rstAt) begin
        Rst = 1'b1; En = 1'b0; aborted = 1'b1;
        break;
      end
    end
    M_ARREADY = 1'b0; M_RVALID = 1'b0; M_RLAST = 1'b0; M_RRESP = 2'b00;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge Clk);
    checks++;
    if ({FirstWord, Completed, Busy, Error, M_ARVALID, M_RREADY} !== 6'd0) begin
      errors++; $display("FAIL reset_flags got %b want 000000",
                         {FirstWord, Completed, Busy, Error, M_ARVALID, M_RREADY});
    end
    checks++;
    if (LineData !== 256'd0 || LineAddress !== 32'd0 || CritWord !== 32'd0 || M_ARADDR !== 32'd0) begin
      errors++; $display("FAIL reset_data got la=%h cw=%h ar=%h want 0", LineAddress, CritWord, M_ARADDR);
    end
    checks++;
    if (M_ARLEN !== 8'd7 || M_ARSIZE !== 3'b010 || M_ARBURST !== 2'b10) begin
      errors++; $display("FAIL ar_consts got len=%0d size=%b burst=%b want 7 010 10",
                         M_ARLEN, M_ARSIZE, M_ARBURST);
    end
    Rst = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_aligned;
    run_fill(32'h0000_1200, 32'hA0, 0, 1'b0, -1, -1, -1);
    checks++;
    if (obsArAddr !== 32'h1200 || obsArCyc != 1) begin
      errors++; $display("FAIL aligned_ar got %h@%0d want 00001200@1", obsArAddr, obsArCyc);
    end
    checks++;
    if (obsFirstCyc != 3 || obsCrit !== 32'hA0 || obsFirstCount != 1) begin
      errors++; $display("FAIL aligned_first got cyc=%0d crit=%h n=%0d want 3 a0 1",
                         obsFirstCyc, obsCrit, obsFirstCount);
    end
    checks++;
    if (obsCompCyc != 10 || Busy !== 1'b0 || obsError !== 1'b0) begin
      errors++; $display("FAIL aligned_done got cyc=%0d busy=%b err=%b want 10 0 0",
                         obsCompCyc, Busy, obsError);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (LineData[i*32 +: 32] !== 32'hA0 + 32'(i)) begin
        errors++; $display("FAIL aligned_word%0d got %h want %h", i, LineData[i*32 +: 32], 32'hA0 + 32'(i));
      end
    end
    checks++;
    if (LineAddress !== 32'h1200) begin
      errors++; $display("FAIL aligned_lineaddr got %h want 00001200", LineAddress);
    end
    En = 1'b0;
    @(negedge Clk);
    checks++;
    if (Completed !== 1'b0 || LineAddress !== 32'h1200) begin
      errors++; $display("FAIL aligned_idle got comp=%b la=%h want 0 00001200", Completed, LineAddress);
    end
  endtask

  task automatic test_crit_first;
    run_fill(32'h0000_0F34, 32'hB0, 0, 1'b0, -1, -1, -1);
    checks++;
    if (obsArAddr !== 32'h0F34 || obsCrit !== 32'hB5 || LineAddress !== 32'h0F20) begin
      errors++; $display("FAIL crit_addr got ar=%h crit=%h la=%h want 00000f34 b5 00000f20",
                         obsArAddr, obsCrit, LineAddress);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (LineData[i*32 +: 32] !== 32'hB0 + 32'(i)) begin
        errors++; $display("FAIL crit_word%0d got %h want %h", i, LineData[i*32 +: 32], 32'hB0 + 32'(i));
      end
    end
    En = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_backpressure;
    run_fill(32'h0000_3368, 32'h50, 3, 1'b1, -1, -1, -1);
    checks++;
    if (arUnstable != 0 || obsArAddr !== 32'h3368) begin
      errors++; $display("FAIL bp_ar_stable got changes=%0d ar=%h want 0 00003368", arUnstable, obsArAddr);
    end
    checks++;
    if (obsFirstCyc != 7 || obsCrit !== 32'h52) begin
      errors++; $display("FAIL bp_first got cyc=%0d crit=%h want 7 52", obsFirstCyc, obsCrit);
    end
    checks++;
    if (obsCompCyc != 21 || obsCompBeats != 8) begin
      errors++; $display("FAIL bp_done got cyc=%0d beats=%0d want 21 8", obsCompCyc, obsCompBeats);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (LineData[i*32 +: 32] !== 32'h50 + 32'(i)) begin
        errors++; $display("FAIL bp_word%0d got %h want %h", i, LineData[i*32 +: 32], 32'h50 + 32'(i));
      end
    end
    En = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_error;
    run_fill(32'h0000_2000, 32'hE0, 0, 1'b0, 3, -1, -1);
    checks++;
    if (obsCompCyc != 10 || obsError !== 1'b1) begin
      errors++; $display("FAIL err_done got cyc=%0d err=%b want 10 1", obsCompCyc, obsError);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      checks++;
      if (Completed !== 1'b1 || Error !== 1'b1) begin
        errors++; $display("FAIL err_hold%0d got comp=%b err=%b want 1 1", k, Completed, Error);
      end
    end
    En = 1'b0;
    @(negedge Clk);
    checks++;
    if (Completed !== 1'b0 || Error !== 1'b1) begin
      errors++; $display("FAIL err_idle got comp=%b err=%b want 0 1", Completed, Error);
    end
    run_fill(32'h0000_2040, 32'hC0, 0, 1'b0, -1, -1, -1);
    checks++;
    if (obsErrAtAr !== 1'b0 || obsError !== 1'b0 || obsCrit !== 32'hC0) begin
      errors++; $display("FAIL err_clear got at_ar=%b done=%b crit=%h want 0 0 c0",
                         obsErrAtAr, obsError, obsCrit);
    end
    En = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_abort;
    run_fill(32'h0000_4004, 32'h70, 0, 1'b0, -1, 2, -1);
    checks++;
    if (obsCompCyc != 10 || LineData[32 +: 32] !== 32'h71 || LineData[0 +: 32] !== 32'h70) begin
      errors++; $display("FAIL abort_done got cyc=%0d w1=%h w0=%h want 10 71 70",
                         obsCompCyc, LineData[32 +: 32], LineData[0 +: 32]);
    end
    @(negedge Clk);
    checks++;
    if (Completed !== 1'b0 || Busy !== 1'b0 || M_ARVALID !== 1'b0) begin
      errors++; $display("FAIL abort_idle got comp=%b busy=%b arv=%b want 0 0 0", Completed, Busy, M_ARVALID);
    end
  endtask

  task automatic test_reset_mid;
    run_fill(32'h0000_5008, 32'h90, 0, 1'b0, -1, -1, 2);
    @(negedge Clk);
    checks++;
    if (!aborted || {FirstWord, Completed, Busy, Error, M_ARVALID, M_RREADY} !== 6'd0) begin
      errors++; $display("FAIL rst_mid_flags got %b want 000000",
                         {FirstWord, Completed, Busy, Error, M_ARVALID, M_RREADY});
    end
    checks++;
    if (LineData !== 256'd0 || LineAddress !== 32'd0 || CritWord !== 32'd0) begin
      errors++; $display("FAIL rst_mid_data got la=%h cw=%h want 0", LineAddress, CritWord);
    end
    Rst = 1'b0;
    run_fill(32'h0000_600C, 32'h30, 0, 1'b0, -1, -1, -1);
    checks++;
    if (obsCompCyc != 10 || obsCrit !== 32'h33 || LineData[7*32 +: 32] !== 32'h37
        || LineAddress !== 32'h6000) begin
      errors++; $display("FAIL rst_refill got cyc=%0d crit=%h w7=%h la=%h want 10 33 37 00006000",
                         obsCompCyc, obsCrit, LineData[7*32 +: 32], LineAddress);
    end
    En = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_crit_first();
    test_backpressure();
    test_error();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
